// File: rtl/datapath_pkg.sv
// Shared types for the scalar issue stage: row states, FU row encodings and producer tags.
// Tag wakeup helper is shared by the dispatch path and every row.
package datapath_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EX   = 2'd2
    } fust_state_t;

    typedef enum logic [1:0] {
        FU_ALU    = 2'd0,
        FU_LD_ST  = 2'd1,
        FU_BRANCH = 2'd2
    } fu_s_t;

    localparam logic [1:0] TAG_READY = 2'd0;
    localparam logic [1:0] TAG_ALU   = 2'd1;
    localparam logic [1:0] TAG_LD    = 2'd2;

    // A tag matching a live, non-ready writeback becomes ready.
    function automatic logic [1:0] wake_tag(input logic [1:0] tag,
                                            input logic       wb_valid,
                                            input logic [1:0] wb_tag);
        logic [1:0] res;
        if (wb_valid && (wb_tag != TAG_READY) && (tag == wb_tag)) begin
            res = TAG_READY;
        end else begin
            res = tag;
        end
        return res;
    endfunction

endpackage

// File: rtl/scalar_issue_if.sv
// Dispatch / writeback / issue / status bundle of the scalar issue stage.
// master drives dispatch, writeback and FU feedback; slave is the issue stage.
interface scalar_issue_if #(
    parameter int NUM_FU = 3,
    parameter int TAG_W  = 2,
    parameter int REG_W  = 5,
    parameter int IMM_W  = 32
);
    logic                    di_en;
    logic [1:0]              di_fu;
    logic [REG_W-1:0]        di_rd;
    logic [REG_W-1:0]        di_rs1;
    logic [REG_W-1:0]        di_rs2;
    logic [IMM_W-1:0]        di_imm;
    logic [TAG_W-1:0]        di_t1;
    logic [TAG_W-1:0]        di_t2;
    logic                    wb_valid;
    logic [TAG_W-1:0]        wb_tag;
    logic                    flush;
    logic [NUM_FU-1:0]       ex_ready;
    logic [NUM_FU-1:0]       fu_done;
    logic                    issue_valid;
    logic [1:0]              issue_fu;
    logic [REG_W-1:0]        issue_rd;
    logic [REG_W-1:0]        issue_rs1;
    logic [REG_W-1:0]        issue_rs2;
    logic [IMM_W-1:0]        issue_imm;
    logic [NUM_FU-1:0]       busy;
    logic [2*NUM_FU-1:0]     row_state;
    logic [TAG_W*NUM_FU-1:0] t1_q;
    logic [TAG_W*NUM_FU-1:0] t2_q;
    logic                    di_err;

    modport master (
        output di_en, di_fu, di_rd, di_rs1, di_rs2, di_imm, di_t1, di_t2,
        output wb_valid, wb_tag, flush, ex_ready, fu_done,
        input  issue_valid, issue_fu, issue_rd, issue_rs1, issue_rs2, issue_imm,
        input  busy, row_state, t1_q, t2_q, di_err
    );

    modport slave (
        input  di_en, di_fu, di_rd, di_rs1, di_rs2, di_imm, di_t1, di_t2,
        input  wb_valid, wb_tag, flush, ex_ready, fu_done,
        output issue_valid, issue_fu, issue_rd, issue_rs1, issue_rs2, issue_imm,
        output busy, row_state, t1_q, t2_q, di_err
    );

endinterface

// File: rtl/scalar_issue_fust_row.sv
// fust_row: one FU status row (IDLE -> WAIT -> EX -> IDLE) holding operands and producer tags.
// Incoming tags are already woken by the parent; stored tags wake here while WAITing.
module fust_row
    import datapath_pkg::*;
#(
    parameter int TAG_W = 2,
    parameter int REG_W = 5,
    parameter int IMM_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             wr,
    input  logic             grant,
    input  logic             flush,
    input  logic             fu_done,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [REG_W-1:0] di_rd,
    input  logic [REG_W-1:0] di_rs1,
    input  logic [REG_W-1:0] di_rs2,
    input  logic [IMM_W-1:0] di_imm,
    input  logic [TAG_W-1:0] di_t1,
    input  logic [TAG_W-1:0] di_t2,
    output fust_state_t      state_q,
    output logic [REG_W-1:0] rd_q,
    output logic [REG_W-1:0] rs1_q,
    output logic [REG_W-1:0] rs2_q,
    output logic [IMM_W-1:0] imm_q,
    output logic [TAG_W-1:0] t1_q,
    output logic [TAG_W-1:0] t2_q,
    output logic             ready,
    output logic             reject
);
    fust_state_t      state_d;
    logic [REG_W-1:0] rd_d, rs1_d, rs2_d;
    logic [IMM_W-1:0] imm_d;
    logic [TAG_W-1:0] t1_d, t2_d;

    assign ready  = (state_q == WAIT) && (t1_q == TAG_READY) && (t2_q == TAG_READY);
    assign reject = wr && (state_q != IDLE);

    // Next-state and capture/wakeup logic for this row.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        case (state_q)
            IDLE: begin
                if (wr) begin
                    rd_d    = di_rd;
                    rs1_d   = di_rs1;
                    rs2_d   = di_rs2;
                    imm_d   = di_imm;
                    t1_d    = di_t1;
                    t2_d    = di_t2;
                    state_d = grant ? EX : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                t1_d = wake_tag(t1_q, wb_valid, wb_tag);
                t2_d = wake_tag(t2_q, wb_valid, wb_tag);
                if (flush) begin
                    state_d = IDLE;
                end else if (grant) begin
                    state_d = EX;
                end else begin
                    state_d = WAIT;
                end
            end
            EX: begin
                if (fu_done) begin
                    state_d = IDLE;
                end else begin
                    state_d = EX;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row registers; reset drops the row whatever state it is in.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
        end
    end

endmodule

// File: rtl/scalar_issue.sv
// scalar_issue: NUM_FU fust_row entries plus a fixed-priority (row 0 first) single-issue arbiter.
// Optional macro SCALAR_ISSUE_BYPASS_EN lets a ready dispatch issue in its own cycle.
module scalar_issue
    import datapath_pkg::*;
#(
    parameter int NUM_FU = 3,
    parameter int TAG_W  = 2,
    parameter int REG_W  = 5,
    parameter int IMM_W  = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    scalar_issue_if.slave bus
);
    logic [TAG_W-1:0]    di_t1_eff_s, di_t2_eff_s;
    logic [NUM_FU-1:0]   row_wr_s, row_ready_s, row_rej_s, elig_s, byp_s, cand_s, grant_s;
    fust_state_t         row_state_s [NUM_FU];
    logic [REG_W-1:0]    row_rd_s    [NUM_FU];
    logic [REG_W-1:0]    row_rs1_s   [NUM_FU];
    logic [REG_W-1:0]    row_rs2_s   [NUM_FU];
    logic [IMM_W-1:0]    row_imm_s   [NUM_FU];
    logic [TAG_W-1:0]    row_t1_s    [NUM_FU];
    logic [TAG_W-1:0]    row_t2_s    [NUM_FU];
    logic                found_s;
    logic [1:0]          issue_fu_s;
    logic [REG_W-1:0]    issue_rd_s, issue_rs1_s, issue_rs2_s;
    logic [IMM_W-1:0]    issue_imm_s;
    logic [NUM_FU-1:0]   busy_s;
    logic [2*NUM_FU-1:0] row_state_pk_s;
    logic [TAG_W*NUM_FU-1:0] t1_pk_s, t2_pk_s;
    logic                di_err_d, di_err_q;

    // A writeback landing with the dispatch is folded into the captured tags.
    assign di_t1_eff_s = wake_tag(bus.di_t1, bus.wb_valid, bus.wb_tag);
    assign di_t2_eff_s = wake_tag(bus.di_t2, bus.wb_valid, bus.wb_tag);

    for (genvar g = 0; g < NUM_FU; g++) begin : g_row
        assign row_wr_s[g] = bus.di_en && !bus.flush && (bus.di_fu == 2'(g));
        assign elig_s[g]   = row_ready_s[g] && bus.ex_ready[g];
`ifdef SCALAR_ISSUE_BYPASS_EN
        assign byp_s[g] = row_wr_s[g] && (row_state_s[g] == IDLE) &&
                          (di_t1_eff_s == TAG_READY) && (di_t2_eff_s == TAG_READY) &&
                          bus.ex_ready[g];
`else
        assign byp_s[g] = 1'b0;
`endif

        fust_row #(.TAG_W(TAG_W), .REG_W(REG_W), .IMM_W(IMM_W)) u_row (
            .CLK      (CLK),
            .nRST     (nRST),
            .wr       (row_wr_s[g]),
            .grant    (grant_s[g]),
            .flush    (bus.flush),
            .fu_done  (bus.fu_done[g]),
            .wb_valid (bus.wb_valid),
            .wb_tag   (bus.wb_tag),
            .di_rd    (bus.di_rd),
            .di_rs1   (bus.di_rs1),
            .di_rs2   (bus.di_rs2),
            .di_imm   (bus.di_imm),
            .di_t1    (di_t1_eff_s),
            .di_t2    (di_t2_eff_s),
            .state_q  (row_state_s[g]),
            .rd_q     (row_rd_s[g]),
            .rs1_q    (row_rs1_s[g]),
            .rs2_q    (row_rs2_s[g]),
            .imm_q    (row_imm_s[g]),
            .t1_q     (row_t1_s[g]),
            .t2_q     (row_t2_s[g]),
            .ready    (row_ready_s[g]),
            .reject   (row_rej_s[g])
        );
    end

    // Single-issue arbiter: lowest row wins; a bypassing row issues the dispatch fields.
    always_comb begin
        found_s     = 1'b0;
        cand_s      = '0;
        grant_s     = '0;
        issue_fu_s  = 2'd0;
        issue_rd_s  = '0;
        issue_rs1_s = '0;
        issue_rs2_s = '0;
        issue_imm_s = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            cand_s[i]   = (elig_s[i] | byp_s[i]) & ~bus.flush & nRST;
            grant_s[i]  = cand_s[i] & ~found_s;
            found_s     = found_s | cand_s[i];
            issue_fu_s  = issue_fu_s | (grant_s[i] ? 2'(i) : 2'd0);
            issue_rd_s  = issue_rd_s  | ({REG_W{grant_s[i]}} & (byp_s[i] ? bus.di_rd  : row_rd_s[i]));
            issue_rs1_s = issue_rs1_s | ({REG_W{grant_s[i]}} & (byp_s[i] ? bus.di_rs1 : row_rs1_s[i]));
            issue_rs2_s = issue_rs2_s | ({REG_W{grant_s[i]}} & (byp_s[i] ? bus.di_rs2 : row_rs2_s[i]));
            issue_imm_s = issue_imm_s | ({IMM_W{grant_s[i]}} & (byp_s[i] ? bus.di_imm : row_imm_s[i]));
        end
    end

    // Pack per-row registered status onto the flat status buses.
    always_comb begin
        busy_s         = '0;
        row_state_pk_s = '0;
        t1_pk_s        = '0;
        t2_pk_s        = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            busy_s[i]                   = (row_state_s[i] != IDLE);
            row_state_pk_s[2*i +: 2]    = row_state_s[i];
            t1_pk_s[TAG_W*i +: TAG_W]   = row_t1_s[i];
            t2_pk_s[TAG_W*i +: TAG_W]   = row_t2_s[i];
        end
    end

    assign di_err_d = |row_rej_s;

    // Rejected-dispatch flag, visible for exactly the cycle after the attempt.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            di_err_q <= 1'b0;
        end else begin
            di_err_q <= di_err_d;
        end
    end

    assign bus.issue_valid = found_s;
    assign bus.issue_fu    = issue_fu_s;
    assign bus.issue_rd    = issue_rd_s;
    assign bus.issue_rs1   = issue_rs1_s;
    assign bus.issue_rs2   = issue_rs2_s;
    assign bus.issue_imm   = issue_imm_s;
    assign bus.busy        = busy_s;
    assign bus.row_state   = row_state_pk_s;
    assign bus.t1_q        = t1_pk_s;
    assign bus.t2_q        = t2_pk_s;
    assign bus.di_err      = di_err_q;

endmodule

// File: tb/tb_scalar_issue.sv
// Bench for scalar_issue: directed scenarios with literal expectations plus random traffic,
// all cross-checked every cycle against a behavioural row-table model.
`timescale 1ns/1ps
module tb_scalar_issue;
    import datapath_pkg::*;

    localparam int NUM_FU = 3;
    localparam int TAG_W  = 2;
    localparam int REG_W  = 5;
    localparam int IMM_W  = 32;
`ifdef SCALAR_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    scalar_issue_if #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .REG_W(REG_W), .IMM_W(IMM_W)) bus ();

    scalar_issue #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .REG_W(REG_W), .IMM_W(IMM_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: state per row as 0 idle, 1 waiting, 2 executing.
    int          m_st  [3];
    logic [4:0]  m_rd  [3];
    logic [4:0]  m_rs1 [3];
    logic [4:0]  m_rs2 [3];
    logic [31:0] m_imm [3];
    logic [1:0]  m_t1  [3];
    logic [1:0]  m_t2  [3];
    logic        m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] eff(input logic [1:0] t);
        return (bus.wb_valid && bus.wb_tag != 2'd0 && t == bus.wb_tag) ? 2'd0 : t;
    endfunction

    // Which row (if any) issues now, and whether it is the incoming dispatch.
    task automatic pick(output int win, output bit byp);
        win = -1;
        byp = 1'b0;
        if (!bus.flush) begin
            for (int i = 0; i < 3; i++) begin
                if (win < 0) begin
                    if (m_st[i] == 1 && m_t1[i] == 2'd0 && m_t2[i] == 2'd0 && bus.ex_ready[i]) begin
                        win = i;
                    end else if (BYP && bus.di_en && bus.di_fu == i && m_st[i] == 0 &&
                                 eff(bus.di_t1) == 2'd0 && eff(bus.di_t2) == 2'd0 && bus.ex_ready[i]) begin
                        win = i;
                        byp = 1'b1;
                    end
                end
            end
        end
    endtask

    // Model update at each active edge (async reset clears everything).
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 3; i++) begin
                m_st[i] = 0; m_rd[i] = '0; m_rs1[i] = '0; m_rs2[i] = '0;
                m_imm[i] = '0; m_t1[i] = '0; m_t2[i] = '0;
            end
            m_err = 1'b0;
        end else begin
            int w;
            bit b;
            int old [3];
            int r;
            pick(w, b);
            old   = m_st;
            m_err = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (old[i] == 1) begin
                    if (bus.flush) m_st[i] = 0;
                    else if (w == i) m_st[i] = 2;
                    else begin
                        m_t1[i] = eff(m_t1[i]);
                        m_t2[i] = eff(m_t2[i]);
                    end
                end else if (old[i] == 2 && bus.fu_done[i]) begin
                    m_st[i] = 0;
                end
            end
            if (bus.di_en && !bus.flush) begin
                r = int'(bus.di_fu);
                if (old[r] == 0) begin
                    m_rd[r] = bus.di_rd; m_rs1[r] = bus.di_rs1; m_rs2[r] = bus.di_rs2;
                    m_imm[r] = bus.di_imm; m_t1[r] = eff(bus.di_t1); m_t2[r] = eff(bus.di_t2);
                    m_st[r] = (b && w == r) ? 2 : 1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge CLK) begin
        int w;
        bit b;
        if (!nRST) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_row_state", bus.row_state, 0);
            chk("rst_issue_valid", bus.issue_valid, 0);
            chk("rst_di_err", bus.di_err, 0);
        end else begin
            pick(w, b);
            chk("issue_valid", bus.issue_valid, w >= 0);
            if (w >= 0) begin
                chk("issue_fu", bus.issue_fu, w);
                chk("issue_rd",  bus.issue_rd,  b ? bus.di_rd  : m_rd[w]);
                chk("issue_rs1", bus.issue_rs1, b ? bus.di_rs1 : m_rs1[w]);
                chk("issue_rs2", bus.issue_rs2, b ? bus.di_rs2 : m_rs2[w]);
                chk("issue_imm", bus.issue_imm, b ? bus.di_imm : m_imm[w]);
            end
            for (int i = 0; i < 3; i++) begin
                chk("row_state", bus.row_state[2*i +: 2], m_st[i]);
                chk("busy", bus.busy[i], m_st[i] != 0);
                if (m_st[i] == 1) begin
                    chk("t1_q", bus.t1_q[2*i +: 2], m_t1[i]);
                    chk("t2_q", bus.t2_q[2*i +: 2], m_t2[i]);
                end
            end
            chk("di_err", bus.di_err, m_err);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        bus.di_en = 1'b0; bus.wb_valid = 1'b0; bus.wb_tag = 2'd0;
        bus.flush = 1'b0; bus.fu_done = 3'b000; bus.ex_ready = 3'b111;
    endtask

    task automatic disp(input logic [1:0] fu, input logic [4:0] rd, input logic [1:0] t1, input logic [1:0] t2);
        bus.di_en  = 1'b1;
        bus.di_fu  = fu;
        bus.di_rd  = rd;
        bus.di_rs1 = rd + 5'd1;
        bus.di_rs2 = rd + 5'd2;
        bus.di_imm = {27'd0, rd} + 32'h1000;
        bus.di_t1  = t1;
        bus.di_t2  = t2;
    endtask

    initial begin
        quiet();
        disp(2'd0, 5'd0, 2'd0, 2'd0);
        bus.di_en = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_busy", bus.busy, 3'b000);
        chk("reset_issue_valid", bus.issue_valid, 1'b0);
        chk("reset_t1", bus.t1_q, 6'd0);
        nRST = 1'b1;
        tick();

        // First dispatch, ready operands.
        disp(FU_ALU, 5'd5, 2'd0, 2'd0);
        #1;
`ifdef SCALAR_ISSUE_BYPASS_EN
        chk("byp_issue_valid", bus.issue_valid, 1'b1);
        chk("byp_issue_fu", bus.issue_fu, 2'd0);
        chk("byp_issue_rd", bus.issue_rd, 5'd5);
`else
        chk("first_no_issue", bus.issue_valid, 1'b0);
`endif
        tick(); quiet(); #1;
`ifdef SCALAR_ISSUE_BYPASS_EN
        chk("byp_row0_ex", bus.row_state[1:0], 2'd2);
`else
        chk("first_issue_valid", bus.issue_valid, 1'b1);
        chk("first_issue_fu", bus.issue_fu, 2'd0);
        chk("first_issue_rd", bus.issue_rd, 5'd5);
`endif
        tick(); #1;

        // Dispatch into an executing row is rejected.
        chk("row0_ex", bus.row_state[1:0], 2'd2);
        disp(FU_ALU, 5'd9, 2'd1, 2'd0);
        tick(); quiet(); #1;
        chk("di_err_pulse", bus.di_err, 1'b1);
        chk("row0_still_ex", bus.row_state[1:0], 2'd2);
        chk("row0_t1_kept", bus.t1_q[1:0], 2'd0);
        tick(); #1;
        chk("di_err_clear", bus.di_err, 1'b0);
        bus.fu_done = 3'b001;
        tick(); quiet(); #1;
        chk("row0_freed", bus.busy[0], 1'b0);

        // Wakeup by writeback.
        disp(FU_LD_ST, 5'd7, TAG_ALU, 2'd0);
        tick(); quiet(); #1;
        chk("row1_wait", bus.row_state[3:2], 2'd1);
        chk("row1_t1", bus.t1_q[3:2], 2'd1);
        tick();
        bus.wb_valid = 1'b1; bus.wb_tag = TAG_ALU;
        #1;
        chk("row1_not_yet", bus.issue_valid, 1'b0);
        tick(); quiet(); #1;
        chk("row1_t1_woken", bus.t1_q[3:2], 2'd0);
        chk("row1_issue_valid", bus.issue_valid, 1'b1);
        chk("row1_issue_fu", bus.issue_fu, 2'd1);
        chk("row1_issue_rd", bus.issue_rd, 5'd7);
        tick(); #1;
        chk("row1_ex", bus.row_state[3:2], 2'd2);
        bus.fu_done = 3'b010;
        tick(); quiet();

        // Priority: ALU before BRANCH.
        bus.ex_ready = 3'b000;
        disp(FU_ALU, 5'd3, 2'd0, 2'd0);
        tick();
        disp(FU_BRANCH, 5'd4, 2'd0, 2'd0);
        tick(); quiet(); #1;
        chk("prio_first_fu", bus.issue_fu, 2'd0);
        chk("prio_first_rd", bus.issue_rd, 5'd3);
        tick(); #1;
        chk("prio_second_valid", bus.issue_valid, 1'b1);
        chk("prio_second_fu", bus.issue_fu, 2'd2);
        chk("prio_second_rd", bus.issue_rd, 5'd4);
        tick(); #1;
        chk("prio_busy", bus.busy, 3'b101);
        bus.fu_done = 3'b101;
        tick(); quiet();

        // Flush: waiting row dropped, executing row kept, dispatch ignored silently.
        bus.ex_ready = 3'b000;
        disp(FU_ALU, 5'd11, 2'd0, 2'd0);
        tick();
        disp(FU_BRANCH, 5'd12, 2'd0, TAG_LD);
        tick(); quiet(); #1;
        chk("flush_pre_fu", bus.issue_fu, 2'd0);
        tick(); #1;
        chk("flush_row2_t2", bus.t2_q[5:4], 2'd2);
        bus.flush = 1'b1;
        disp(FU_LD_ST, 5'd13, 2'd0, 2'd0);
        #1;
        chk("flush_no_issue", bus.issue_valid, 1'b0);
        tick(); quiet(); #1;
        chk("flush_row2_idle", bus.row_state[5:4], 2'd0);
        chk("flush_row0_ex", bus.row_state[1:0], 2'd2);
        chk("flush_row1_idle", bus.row_state[3:2], 2'd0);
        chk("flush_no_err", bus.di_err, 1'b0);
        bus.fu_done = 3'b001;
        tick(); quiet();

        // Writeback coinciding with capture.
        disp(FU_BRANCH, 5'd14, TAG_LD, 2'd0);
        bus.wb_valid = 1'b1; bus.wb_tag = TAG_LD;
        #1;
`ifdef SCALAR_ISSUE_BYPASS_EN
        chk("cap_wb_byp_valid", bus.issue_valid, 1'b1);
        chk("cap_wb_byp_fu", bus.issue_fu, 2'd2);
`else
        chk("cap_wb_no_issue", bus.issue_valid, 1'b0);
`endif
        tick(); quiet(); #1;
`ifdef SCALAR_ISSUE_BYPASS_EN
        chk("cap_wb_byp_ex", bus.row_state[5:4], 2'd2);
`else
        chk("cap_wb_t1", bus.t1_q[5:4], 2'd0);
        chk("cap_wb_issue_valid", bus.issue_valid, 1'b1);
        chk("cap_wb_issue_fu", bus.issue_fu, 2'd2);
`endif
        tick();
        bus.fu_done = 3'b100;
        tick(); quiet();

        // Reset mid-operation.
        bus.ex_ready = 3'b000;
        disp(FU_ALU, 5'd1, 2'd0, 2'd0);
        tick();
        disp(FU_LD_ST, 5'd2, TAG_ALU, TAG_ALU);
        tick(); quiet();
        bus.ex_ready = 3'b001;
        tick(); #1;
        nRST = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 3'b000);
        chk("midrst_state", bus.row_state, 6'd0);
        chk("midrst_t1", bus.t1_q, 6'd0);
        chk("midrst_issue", bus.issue_valid, 1'b0);
        tick();
        nRST = 1'b1;
        tick();

        // Random traffic, checked by the per-cycle compare.
        for (int n = 0; n < 2000; n++) begin
            bus.di_en    = ($urandom_range(0, 9) < 6);
            bus.di_fu    = 2'($urandom_range(0, 2));
            bus.di_rd    = 5'($urandom);
            bus.di_rs1   = 5'($urandom);
            bus.di_rs2   = 5'($urandom);
            bus.di_imm   = $urandom;
            bus.di_t1    = 2'($urandom_range(0, 2));
            bus.di_t2    = 2'($urandom_range(0, 2));
            bus.wb_valid = ($urandom_range(0, 9) < 4);
            bus.wb_tag   = 2'($urandom_range(0, 2));
            bus.flush    = ($urandom_range(0, 19) == 0);
            bus.ex_ready = 3'($urandom);
            bus.fu_done  = 3'($urandom);
            tick();
        end
        quiet();
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scalar_issue.md
SCALAR_ISSUE -- requirements
Module: scalar_issue

Interface
REQ-001 Parameter NUM_FU, 3, scalar FU rows (0=ALU, 1=LD_ST, 2=BRANCH).
REQ-002 Parameter TAG_W, 2, producer tag width (0=ready, 1=ALU, 2=LD).
REQ-003 Parameter REG_W, 5, scalar register index width.
REQ-004 Parameter IMM_W, 32, immediate width.
REQ-005 Reset nRST, asynchronous, active-low; clock CLK.
REQ-006 CLK  in  1  clock; nRST  in  1  async active-low reset.
REQ-007 di_en  in  1  dispatch writes a row this cycle; di_fu  in  2  target row.
REQ-008 di_rd, di_rs1, di_rs2  in  REG_W each  operand indices; di_imm  in  IMM_W  immediate.
REQ-009 di_t1, di_t2  in  TAG_W each  producer tags for rs1/rs2.
REQ-010 wb_valid  in  1  writeback broadcast; wb_tag  in  TAG_W  producing FU tag.
REQ-011 flush  in  1  squash unissued rows; ex_ready  in  NUM_FU  FU accepts issue; fu_done  in  NUM_FU  FU finished.
REQ-012 issue_valid  out  1; issue_fu  out  2; issue_rd/rs1/rs2  out  REG_W; issue_imm  out  IMM_W.
REQ-013 busy  out  NUM_FU  row not IDLE; row_state  out  2*NUM_FU  per-row state; t1_q, t2_q  out  TAG_W*NUM_FU  stored tags; di_err  out  1  rejected dispatch.

Function
REQ-014 Each row SHALL hold a state machine IDLE(0) -> WAIT(1) -> EX(2) -> IDLE.
REQ-015 IDLE->WAIT on di_en with di_fu matching the row and row IDLE at cycle start; rd/rs1/rs2/imm/tags captured.
REQ-016 di_en to a non-IDLE row SHALL be ignored and pulse di_err for one cycle; fu_done the same cycle does not free the row for that dispatch.
REQ-017 On wb_valid, every WAIT row with t1==wb_tag (wb_tag!=0) SHALL clear t1 to 0 next cycle; likewise t2.
REQ-018 If wb_valid coincides with capture, incoming di_t1/di_t2 equal to wb_tag SHALL be stored as 0.
REQ-019 A WAIT row with t1==0, t2==0 and ex_ready[fu]=1 is eligible; at most one issue per cycle, fixed priority ALU > LD_ST > BRANCH.
REQ-020 Issue is combinational: issue_valid plus that row's fields in the same cycle; row moves WAIT->EX next edge.
REQ-021 EX->IDLE on fu_done[row]; fu_done on a non-EX row is ignored.
REQ-022 flush SHALL return all WAIT rows to IDLE and suppress issue_valid that cycle; EX rows unaffected; di_en in a flush cycle ignored without di_err.
REQ-023 busy[i] = (row_state[i] != IDLE), registered state, no combinational path from di_en.

Reset
REQ-024 On nRST low all rows IDLE, all stored fields and tags 0, issue_valid=0, di_err=0, busy=0, independent of CLK.
REQ-025 Reset mid-operation SHALL drop all rows including EX; no fu_done expected afterwards.

Configuration
REQ-026 Macro SCALAR_ISSUE_BYPASS_EN defined: a dispatch with effective tags 0 and ex_ready=1 SHALL issue in the dispatch cycle (row goes IDLE->EX directly), subject to REQ-019 priority against existing rows.
REQ-027 Macro undefined: every dispatched row spends at least one cycle in WAIT before issue.

Structure
REQ-028 fust_state_t (IDLE/WAIT/EX), fu_s_t row encodings, tag constants TAG_READY/TAG_ALU/TAG_LD SHALL live in datapath_pkg.
REQ-029 One sub-module fust_row (single row state machine, tag wakeup) instantiated NUM_FU times; issue arbiter in the parent.

Verification
REQ-030 Reset then di_en fu=0 rd=5 t1=0 t2=0, ex_ready=111 -> issue_valid next cycle with issue_fu=0, issue_rd=5 (bypass off); same cycle with bypass on.
REQ-031 di_en fu=1 t1=1; wb_valid wb_tag=1 two cycles later -> t1_q row1 becomes 0, issue_fu=1 following cycle.
REQ-032 ALU and BRANCH rows both ready, ex_ready=111 -> ALU issues first, BRANCH one cycle later.
REQ-033 Row0 in EX, di_en fu=0 -> di_err=1 one cycle, row0 fields unchanged; fu_done[0] -> busy[0]=0 next cycle.
REQ-034 Row2 WAIT t2=2, row0 EX, flush=1 -> row2 IDLE, row0 still EX, issue_valid=0.
REQ-035 di_en fu=2 t1=2 with wb_valid wb_tag=2 same cycle -> stored t1=0, row eligible next cycle.
